// File: rtl/seq_shifter_rev_if.sv
// Request/response bundle for the sequential reverse-direction shifter.
//
// Request side : Shift_In (operand), Shift_Val (amount), Mode (operation),
//                in_valid / in_ready handshake.
// Response side: Shift_Out (result), Ovf (SLA overflow), out_valid /
//                out_ready handshake, busy (unit occupied).
//
// slave  : the shifter itself.
// master : whoever issues requests and consumes results.
interface seq_shifter_rev_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) ();
    logic [WIDTH-1:0] Shift_In;
    logic [CNT_W-1:0] Shift_Val;
    logic [1:0]       Mode;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] Shift_Out;
    logic             Ovf;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    modport slave (
        input  Shift_In, Shift_Val, Mode, in_valid, out_ready,
        output in_ready, Shift_Out, Ovf, out_valid, busy
    );

    modport master (
        output Shift_In, Shift_Val, Mode, in_valid, out_ready,
        input  in_ready, Shift_Out, Ovf, out_valid, busy
    );
endinterface

// File: rtl/seq_shifter_rev.sv
// Multi-cycle, one-bit-per-cycle shifter for the ALU slow path.
// Operations (Mode): 00 logical right, 01 arithmetic left with overflow
// detect, 10 rotate left, 11 pass-through.
//
// Ports:
//   clk : clock, rising-edge.
//   rst : asynchronous, active-high reset.
//   bus : seq_shifter_rev_if.slave -- request (Shift_In, Shift_Val, Mode,
//         in_valid/in_ready) and response (Shift_Out, Ovf,
//         out_valid/out_ready, busy).
//
// Flow: IDLE accepts a request and loads the operand; RUN performs one
// single-bit step per cycle until the count expires; DONE presents the
// result until the consumer takes it, then returns to IDLE.
module seq_shifter_rev #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    seq_shifter_rev_if.slave    bus
);

    localparam logic [1:0] MODE_SRL  = 2'b00;
    localparam logic [1:0] MODE_SLA  = 2'b01;
    localparam logic [1:0] MODE_ROL  = 2'b10;
    localparam logic [1:0] MODE_NONE = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] data_reg,  data_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [1:0]       mode_reg,  mode_next;
    logic             ovf_reg,   ovf_next;

    // Single-bit step results for each operation, built bit by bit.
    logic [WIDTH-1:0] srl_step;
    logic [WIDTH-1:0] sla_step;
    logic [WIDTH-1:0] rol_step;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_step
        if (gi == WIDTH - 1) begin : g_msb
            assign srl_step[gi] = 1'b0;
        end else begin : g_lo
            assign srl_step[gi] = data_reg[gi+1];
        end

        if (gi == 0) begin : g_lsb
            assign sla_step[gi] = 1'b0;
            assign rol_step[gi] = data_reg[WIDTH-1];
        end else begin : g_hi
            assign sla_step[gi] = data_reg[gi-1];
            assign rol_step[gi] = data_reg[gi-1];
        end
    end

    // A left step overflows when the sign bit is about to change, i.e. the
    // two top bits of the value before the step differ.
    logic sla_sign_change;
    assign sla_sign_change = data_reg[WIDTH-1] ^ data_reg[WIDTH-2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            data_reg  <= '0;
            count_reg <= '0;
            mode_reg  <= MODE_SRL;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            count_reg <= count_next;
            mode_reg  <= mode_next;
            ovf_reg   <= ovf_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        count_next = count_reg;
        mode_next  = mode_reg;
        ovf_next   = ovf_reg;

        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    data_next  = bus.Shift_In;
                    mode_next  = bus.Mode;
                    ovf_next   = 1'b0;
                    // Pass-through is treated as a zero-length shift.
                    count_next = (bus.Mode == MODE_NONE) ? '0 : bus.Shift_Val;
                    state_next = (count_next == '0) ? DONE : RUN;
                end
            end

            RUN: begin
                case (mode_reg)
                    MODE_SRL: data_next = srl_step;
                    MODE_SLA: begin
                        data_next = sla_step;
                        ovf_next  = ovf_reg | sla_sign_change;
                    end
                    MODE_ROL: data_next = rol_step;
                    default:  data_next = data_reg;
                endcase
                count_next = count_reg - CNT_W'(1);
                if (count_reg == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.busy      = (state_reg != IDLE);
    assign bus.Shift_Out = data_reg;
    // The accumulator only ever sets in SLA and is cleared on accept, so
    // gating with DONE is enough to keep Ovf at 0 for other modes.
    assign bus.Ovf       = (state_reg == DONE) & ovf_reg;

endmodule

// File: tb/tb_seq_shifter_rev.sv
// Randomized self-checking bench for seq_shifter_rev: directed cases from
// the shifter's behaviour, handshake/backpressure and mid-operation reset,
// then random requests checked against an arithmetic reference model.
module tb_seq_shifter_rev;

    localparam int WIDTH = 16;
    localparam int CNT_W = 4;
    localparam logic [1:0] M_SRL  = 2'b00;
    localparam logic [1:0] M_SLA  = 2'b01;
    localparam logic [1:0] M_ROL  = 2'b10;
    localparam logic [1:0] M_NONE = 2'b11;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   txn;

    seq_shifter_rev_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    seq_shifter_rev #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h (txn %0d)", tag, got, exp, txn);
        end
    endtask

    // Result computed directly from the operation definitions.
    function automatic void ref_model(input logic [15:0] d, input int n, input logic [1:0] m,
                                      output logic [15:0] r, output logic o);
        logic [31:0] wide;
        logic [31:0] top;
        r = d;
        o = 1'b0;
        case (m)
            M_SRL: r = d >> n;
            M_SLA: begin
                r   = 16'(32'(d) << n);
                // Overflow iff the top n+1 bits are not all equal.
                top = 32'(d) >> (15 - n);
                o   = (top != 32'd0) && (top != ((32'd1 << (n + 1)) - 32'd1));
            end
            M_ROL: begin
                wide = {d, d};
                wide = wide << n;
                r    = wide[31:16];
            end
            default: r = d;
        endcase
    endfunction

    // Waits for out_valid, counting edges after the accept edge.
    task automatic wait_result(output int edges);
        edges = 0;
        while (!bus.out_valid && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic run_op(input logic [15:0] d, input int n, input logic [1:0] m, input int hold);
        logic [15:0] er;
        logic        eo;
        int          edges;
        int          exp_lat;
        ref_model(d, n, m, er, eo);
        exp_lat = (m == M_NONE) ? 0 : n;
        txn++;
        @(negedge clk);
        bus.Shift_In  = d;
        bus.Shift_Val = 4'(n);
        bus.Mode      = m;
        bus.in_valid  = 1'b1;
        check_eq("in_ready_idle", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        // Scramble inputs after accept; they must not affect the operation.
        bus.in_valid  = 1'b0;
        bus.Shift_In  = 16'($urandom);
        bus.Shift_Val = 4'($urandom);
        bus.Mode      = 2'($urandom);
        wait_result(edges);
        check_eq("latency", 32'(edges), 32'(exp_lat));
        check_eq("shift_out", 32'(bus.Shift_Out), 32'(er));
        check_eq("ovf", 32'(bus.Ovf), 32'(eo));
        check_eq("busy_done", 32'(bus.busy), 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_eq("hold_valid", 32'(bus.out_valid), 32'd1);
            check_eq("hold_data", 32'(bus.Shift_Out), 32'(er));
            check_eq("hold_ovf", 32'(bus.Ovf), 32'(eo));
            check_eq("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check_eq("release_valid", 32'(bus.out_valid), 32'd0);
        check_eq("release_in_ready", 32'(bus.in_ready), 32'd1);
        $display("txn %0d mode=%0d in=0x%04h amt=%0d hold=%0d -> out=0x%04h ovf=%0b lat=%0d",
                 txn, m, d, n, hold, er, eo, edges);
    endtask

    initial begin
        int edges;
        checks = 0;
        errors = 0;
        txn    = 0;
        bus.Shift_In  = '0;
        bus.Shift_Val = '0;
        bus.Mode      = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_shift_out", 32'(bus.Shift_Out), 32'd0);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_ovf", 32'(bus.Ovf), 32'd0);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        run_op(16'h8001, 4,  M_SRL, 0);
        run_op(16'h8001, 1,  M_ROL, 0);
        run_op(16'h0001, 15, M_ROL, 0);
        run_op(16'h4000, 1,  M_SLA, 0);
        run_op(16'hC000, 1,  M_SLA, 0);
        run_op(16'h2000, 3,  M_SLA, 0);
        run_op(16'hA5A5, 0,  M_SRL, 0);
        run_op(16'hA5A5, 9,  M_NONE, 5);
        run_op(16'hFFFF, 15, M_SRL, 2);

        // Pending request during DONE is accepted only after the consume edge.
        txn++;
        @(negedge clk);
        bus.Shift_In = 16'h8001; bus.Shift_Val = 4'd1; bus.Mode = M_ROL; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_result(edges);
        check_eq("pend_first_lat", 32'(edges), 32'd1);
        check_eq("pend_first_out", 32'(bus.Shift_Out), 32'h0003);
        bus.Shift_In = 16'h0001; bus.Shift_Val = 4'd15; bus.Mode = M_ROL; bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check_eq("pend_consume_valid", 32'(bus.out_valid), 32'd0);
        check_eq("pend_consume_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check_eq("pend_accept_busy", 32'(bus.busy), 32'd1);
        check_eq("pend_accept_in_ready", 32'(bus.in_ready), 32'd0);
        wait_result(edges);
        check_eq("pend_second_lat", 32'(edges), 32'd15);
        check_eq("pend_second_out", 32'(bus.Shift_Out), 32'h8000);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check_eq("pend_second_release", 32'(bus.in_ready), 32'd1);
        $display("txn %0d pending-request handshake sequence", txn);

        // Asynchronous reset in the middle of a long shift.
        txn++;
        @(negedge clk);
        bus.Shift_In = 16'hFFFF; bus.Shift_Val = 4'd10; bus.Mode = M_SRL; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("pre_rst_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("async_rst_valid", 32'(bus.out_valid), 32'd0);
        check_eq("async_rst_busy", 32'(bus.busy), 32'd0);
        check_eq("async_rst_out", 32'(bus.Shift_Out), 32'd0);
        check_eq("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        $display("txn %0d mid-operation asynchronous reset", txn);
        run_op(16'h1234, 4, M_ROL, 0);

        // Random traffic.
        for (int k = 0; k < 50; k++) begin
            run_op(16'($urandom), int'($urandom_range(0, 15)), 2'($urandom),
                   int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
